// File: rtl/seg_flags_pkg.sv
// Shared segment/flag code constants and decode helper.
// Used by the flag encoder and by seg_flag_decoder.
package seg_flags_pkg;

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] FLG_Z    = 3'b001;
  localparam logic [2:0] FLG_N    = 3'b010;
  localparam logic [2:0] FLG_C    = 3'b100;
  localparam logic [2:0] FLG_NONE = 3'b000;

  typedef struct packed {
    logic [2:0] flags;
    logic       err;
  } seg_dec_t;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } hs_state_t;

  function automatic seg_dec_t seg_to_flags(
    input logic [6:0] seg
  );
    seg_dec_t d;
    d.flags = FLG_NONE;
    d.err   = 1'b0;
    unique case (1'b1)
      (seg == SEG_E):     d.flags = FLG_Z;
      (seg == SEG_MINUS): d.flags = FLG_N;
      (seg == SEG_C):     d.flags = FLG_C;
      (seg == SEG_BLANK): d.flags = FLG_NONE;
      default:            d.err   = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_stability_filter.sv
// Samples the segment bus and strobes stable_evt once per new stable pattern.
// Ports: clk, rst, segments_in -> stable_evt, stable_seg.
module seg_stability_filter
  import seg_flags_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments_in,
  output logic       stable_evt,
  output logic [6:0] stable_seg
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [6:0] sample_q;
  logic [6:0] last_seg;
  logic [7:0] cnt;

  // Fires once: last_seg catches up with sample_q on the same edge.
  assign stable_evt = (cnt == CNT_MAX) &&
                      (sample_q != last_seg);
  assign stable_seg = sample_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= SEG_BLANK;
      last_seg <= SEG_BLANK;
      cnt      <= CNT_MAX;
    end else begin
      sample_q <= segments_in;
      if (segments_in != sample_q)
        cnt <= 8'd1;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
      if (stable_evt)
        last_seg <= sample_q;
    end
  end

endmodule

// File: rtl/seg_flag_decoder.sv
// Decodes stable 7-seg patterns back to C/N/Z flags over valid/ready.
// Ports: clk, rst, segments_in, out_ready -> flags_C_N_Z, code_err,
// out_valid; err_count only when SEGDEC_ERR_CNT_EN is defined.
module seg_flag_decoder
  import seg_flags_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments_in,
  output logic [2:0] flags_C_N_Z,
  output logic       code_err,
  output logic       out_valid,
  input  logic       out_ready
`ifdef SEGDEC_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  logic       evt;
  logic [6:0] seg;
  seg_dec_t   dec;
  hs_state_t  state_q;
  hs_state_t  state_d;

  seg_stability_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filt (
    .clk        (clk),
    .rst        (rst),
    .segments_in(segments_in),
    .stable_evt (evt),
    .stable_seg (seg)
  );

  assign dec = seg_to_flags(seg);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_EMPTY;
    else
      state_q <= state_d;
  end

  // A new event always wins over a pending result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (evt) state_d = S_FULL;
      S_FULL: begin
        if (evt)
          state_d = S_FULL;
        else if (out_ready)
          state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign out_valid = (state_q == S_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_C_N_Z <= FLG_NONE;
      code_err    <= 1'b0;
    end else if (evt) begin
      flags_C_N_Z <= dec.flags;
      code_err    <= dec.err;
    end
  end

`ifdef SEGDEC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= 8'd0;
    else if (evt && dec.err &&
             err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seg_flag_decoder.sv
// Self-checking bench for seg_flag_decoder.
// Table vectors, directed corner sequences and a window-based model.
module tb_seg_flag_decoder;

  localparam int S = 4;
  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] EE = 7'b0000110;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] CC = 7'b1000110;
  localparam logic [6:0] XX = 7'b0101010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segments_in = B;
  logic       out_ready = 1'b0;
  logic [2:0] flags_C_N_Z;
  logic       code_err;
  logic       out_valid;
`ifdef SEGDEC_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  seg_flag_decoder #(
    .STABLE_CYCLES(S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .segments_in(segments_in),
    .flags_C_N_Z(flags_C_N_Z),
    .code_err   (code_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef SEGDEC_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: pattern is stable when the last S captured samples match.
  logic [6:0] hist[$];
  logic [6:0] m_last;
  logic       m_valid;
  logic [2:0] m_flags;
  logic       m_err;
  int         m_errcnt;

  function automatic logic [3:0] ref_dec(input logic [6:0] s);
    case (s)
      7'b0000110: return 4'b0010;
      7'b0111111: return 4'b0100;
      7'b1000110: return 4'b1000;
      7'b1111111: return 4'b0000;
      default:    return 4'b0001;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [6:0] s,
                            input logic rdy, input logic r);
    logic stable;
    logic [3:0] d;
    if (r) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(B);
      m_last = B;
      m_valid = 1'b0;
      m_flags = 3'b000;
      m_err = 1'b0;
      m_errcnt = 0;
      return;
    end
    stable = 1'b1;
    foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
    if (hist[0] == m_last) stable = 1'b0;
    if (stable) begin
      d = ref_dec(hist[0]);
      m_flags = d[3:1];
      m_err = d[0];
      m_last = hist[0];
      m_valid = 1'b1;
      if (m_err && m_errcnt < 255) m_errcnt++;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    hist.push_back(s);
    if (hist.size() > S) void'(hist.pop_front());
  endtask

  task automatic step(input logic [6:0] s,
                      input logic rdy, input logic r);
    segments_in = s;
    out_ready = rdy;
    rst = r;
    @(posedge clk);
    model_edge(s, rdy, r);
    #1;
    chk("model_valid", int'(out_valid), int'(m_valid));
    chk("model_flags", int'(flags_C_N_Z), int'(m_flags));
    chk("model_err", int'(code_err), int'(m_err));
`ifdef SEGDEC_ERR_CNT_EN
    chk("model_errcnt", int'(err_count), m_errcnt);
`endif
  endtask

  typedef struct {
    logic [6:0] seg;
    logic       rdy;
    logic       r;
    logic       v;
    logic [2:0] f;
    logic       e;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int seen;
    logic [2:0] seenf;
    logic [6:0] cur;
    int len;

    tbl[0]  = '{B,  1, 1, 0, 3'b000, 0};
    tbl[1]  = '{B,  1, 0, 0, 3'b000, 0};
    tbl[2]  = '{B,  1, 0, 0, 3'b000, 0};
    tbl[3]  = '{B,  1, 0, 0, 3'b000, 0};
    tbl[4]  = '{EE, 1, 0, 0, 3'b000, 0};
    tbl[5]  = '{EE, 1, 0, 0, 3'b000, 0};
    tbl[6]  = '{EE, 1, 0, 0, 3'b000, 0};
    tbl[7]  = '{EE, 1, 0, 0, 3'b000, 0};
    tbl[8]  = '{EE, 1, 0, 1, 3'b001, 0};
    tbl[9]  = '{EE, 1, 0, 0, 3'b001, 0};
    tbl[10] = '{EE, 1, 0, 0, 3'b001, 0};
    tbl[11] = '{CC, 0, 0, 0, 3'b001, 0};
    tbl[12] = '{CC, 0, 0, 0, 3'b001, 0};
    tbl[13] = '{CC, 0, 0, 0, 3'b001, 0};
    tbl[14] = '{CC, 0, 0, 0, 3'b001, 0};
    tbl[15] = '{CC, 0, 0, 1, 3'b100, 0};
    tbl[16] = '{CC, 0, 0, 1, 3'b100, 0};
    tbl[17] = '{CC, 1, 0, 0, 3'b100, 0};
    tbl[18] = '{XX, 1, 0, 0, 3'b100, 0};
    tbl[19] = '{XX, 1, 0, 0, 3'b100, 0};
    tbl[20] = '{XX, 1, 0, 0, 3'b100, 0};
    tbl[21] = '{XX, 1, 0, 0, 3'b100, 0};
    tbl[22] = '{XX, 1, 0, 1, 3'b000, 1};
    tbl[23] = '{XX, 0, 0, 1, 3'b000, 1};

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].seg, tbl[i].rdy, tbl[i].r);
      chk("tbl_valid", int'(out_valid), int'(tbl[i].v));
      chk("tbl_flags", int'(flags_C_N_Z), int'(tbl[i].f));
      chk("tbl_err", int'(code_err), int'(tbl[i].e));
    end

    // Blank held after reset never reports.
    step(B, 1, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(B, 1, 0);
      if (out_valid) seen++;
    end
    chk("blank_quiet", seen, 0);

    // Glitching bus gives nothing; then held C reports once.
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step((i % 2) ? CC : MI, 1, 0);
      if (out_valid) seen++;
      step((i % 2) ? CC : MI, 1, 0);
      if (out_valid) seen++;
    end
    chk("toggle_quiet", seen, 0);
    seenf = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step(CC, 1, 0);
      if (out_valid) begin
        seen++;
        seenf = flags_C_N_Z;
      end
    end
    chk("hold_c_once", seen, 1);
    chk("hold_c_flags", int'(seenf), 3'b100);

    // Overwrite while stalled, then one transfer.
    for (int i = 0; i < 6; i++) step(MI, 0, 0);
    chk("ovr_v1", int'(out_valid), 1);
    chk("ovr_f1", int'(flags_C_N_Z), 3'b010);
    for (int i = 0; i < 6; i++) step(EE, 0, 0);
    chk("ovr_v2", int'(out_valid), 1);
    chk("ovr_f2", int'(flags_C_N_Z), 3'b001);
    step(EE, 1, 0);
    chk("ovr_xfer", int'(out_valid), 0);
    step(EE, 1, 0);
    step(EE, 1, 0);
    chk("ovr_no_more", int'(out_valid), 0);

    // Reset drops a pending result; held pattern reappears.
    for (int i = 0; i < 6; i++) step(MI, 0, 0);
    chk("rst_pre_v", int'(out_valid), 1);
    step(MI, 0, 1);
    chk("rst_v", int'(out_valid), 0);
    chk("rst_f", int'(flags_C_N_Z), 0);
    seen = 0;
    for (int i = 0; i < S; i++) begin
      step(MI, 0, 0);
      if (out_valid) seen++;
    end
    chk("rst_wait", seen, 0);
    step(MI, 0, 0);
    chk("rst_rerep_v", int'(out_valid), 1);
    chk("rst_rerep_f", int'(flags_C_N_Z), 3'b010);

    // Error pattern and counter saturation.
    step(B, 1, 1);
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 5; i++) step(XX, 1, 0);
      if (n == 0) begin
        chk("err_v", int'(out_valid), 1);
        chk("err_e", int'(code_err), 1);
        chk("err_f", int'(flags_C_N_Z), 0);
`ifdef SEGDEC_ERR_CNT_EN
        chk("err_cnt1", int'(err_count), 1);
`endif
      end
      for (int i = 0; i < 5; i++) step(B, 1, 0);
    end
`ifdef SEGDEC_ERR_CNT_EN
    chk("err_cnt_sat", int'(err_count), 255);
`endif

    // Random traffic against the model.
    cur = B;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0: cur = EE;
        1: cur = MI;
        2: cur = CC;
        3: cur = B;
        4: cur = 7'($urandom);
        default: ;
      endcase
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        step(cur, $urandom_range(0, 3) != 0,
             $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_flag_decoder.md
# seg_flag_decoder

Receive-side counterpart of the flag-to-display encoder. It samples a 7-bit active-low segment bus and waits for the pattern to stay stable for a programmable number of cycles. It then decodes the pattern back into the `C/N/Z` flag code and delivers each new stable value over a valid/ready handshake. It is used for loopback self-check of the ALU display path and as a board-level display monitor.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern counts as stable; legal range 1..255.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `segments_in` input, 7 bits: segment lines, bit 6..0 = segment g..a, active-low (0 = lit).
- `flags_C_N_Z` output, 3 bits: decoded flags.
- `code_err` output, 1 bit: reported pattern is not a legal code.
- `out_valid` output, 1 bit: `flags_C_N_Z` and `code_err` hold an unconsumed result.
- `out_ready` input, 1 bit: consumer accepts the result.
- `err_count` output, 8 bits: present only with `SEGDEC_ERR_CNT_EN`.

## Operation
- Decode table:
  - 0000110 (E) → 001
  - 0111111 (minus) → 010
  - 1000110 (C) → 100
  - 1111111 (blank) → 000
  - Every other pattern → flags 000, `code_err` = 1.
- Input register `sample_q` captures `segments_in` every cycle.
- Stability counter `cnt` is 8 bits and saturates at `STABLE_CYCLES`.
  - It resets to 1 when the new sample differs from `sample_q`.
  - Otherwise it increments.
- **Stable event:** `cnt` reaches `STABLE_CYCLES` and `sample_q` ≠ `last_seg`, where `last_seg` is the last pattern loaded to the output.
  - A pattern that stays stable produces exactly one event.
  - A pattern that returns after a different pattern produces a new event.
- **Load:** on an event, the decoded flags and error go to the outputs, `last_seg` ← `sample_q`, and `out_valid` ← 1.
- **States:**
  - EMPTY (`out_valid` = 0) → FULL on event.
  - FULL → EMPTY on `out_valid && out_ready` with no event in the same cycle.
  - FULL with an event in the same cycle (ready or not) → stays FULL with the new data; the newest result wins and the older one is lost.
- An unstable or glitching bus never produces output.

## Timing
- **Reset values:**
  - `flags_C_N_Z` = 000, `code_err` = 0, `out_valid` = 0.
  - `sample_q` = `last_seg` = 1111111, `cnt` = `STABLE_CYCLES`.
  - `err_count` = 0.
  - A blank bus after reset is therefore not reported.
- **Latency:** a new pattern first present at edge k gives `out_valid` = 1 after edge k+`STABLE_CYCLES`.
- `out_valid` and data stay constant while `out_ready` = 0, unless a newer event overwrites them.
- `out_ready` is sampled only while `out_valid` = 1; there is no combinational path from `out_ready` to any output.
- `rst` asserted mid-operation clears everything at that edge, including a pending result.
- `STABLE_CYCLES` = 1: an event occurs on the first edge a new pattern is captured.

## Configuration
- `SEGDEC_ERR_CNT_EN` defined:
  - Port `err_count` exists.
  - It increments by 1 on every load with `code_err` = 1 and saturates at 255.
- `SEGDEC_ERR_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `seg_flags_pkg` holds:
  - Constants `SEG_E`, `SEG_MINUS`, `SEG_C`, `SEG_BLANK` (7-bit).
  - Constants `FLG_Z`, `FLG_N`, `FLG_C`, `FLG_NONE` (3-bit).
  - Decode function `seg_to_flags` returning flags plus an error bit.
  - The encoder side imports the same constants.
- Sub-module `seg_stability_filter` contains `sample_q`, `cnt` and `last_seg`, and emits a one-cycle `event` strobe with the stable pattern.
- Top level contains decode, the output register, the handshake FSM and the optional counter.

## Test plan
- **Reset, then bus held at 1111111 for 20 cycles:** `out_valid` stays 0, all outputs 0.
- **0000110 applied at edge 10, `out_ready` = 1, `STABLE_CYCLES` = 4:** `out_valid` = 1 after edge 14 for one cycle, flags = 001, `code_err` = 0; no further events while held.
- **0111111 toggled with 1000110 every 2 cycles for 20 cycles:** no output. Then 1000110 held: one result with flags 100.
- **`out_ready` = 0; 0111111 stable, then 0000110 stable:** `out_valid` stays 1 and data changes from 010 to 001. Ready raised: one transfer, then `out_valid` = 0.
- **Pattern 0101010 held, with `SEGDEC_ERR_CNT_EN`:** flags = 000, `code_err` = 1, `err_count` = 1. Repeat with blank in between 300 times: `err_count` saturates at 255.
- **`rst` pulsed while `out_valid` = 1 and ready low:** `out_valid` = 0 after that edge. The same pattern, still held, is re-reported `STABLE_CYCLES` edges after `rst` deasserts.
